// File: rtl/inst_rom_arbiter.sv
// Two-master arbiter for the instruction-ROM read port.
// Default build: fixed priority to fetch with a starvation guard for the debug
// master. Defining ARB_ROUND_ROBIN_EN alternates masters on contention instead.
module inst_rom_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_valid,
    output logic              stallreq,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_valid,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    typedef enum logic [1:0] {GNT_NONE, GNT_M0, GNT_M1} gnt_e;

    gnt_e              last_gnt_reg, last_gnt_next;
    logic              pick_m1;
    logic [1:0]        gnt_vec;
    logic [DATA_W-1:0] rdata_reg [2];

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the master that did not win last cycle goes next.
    always_comb pick_m1 = (last_gnt_reg == GNT_M0);
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_reg, starve_cnt_next;

    always_comb pick_m1 = (starve_cnt_reg >= LIMIT);

    always_comb begin
        starve_cnt_next = 4'd0;
        if (m1_req && !m1_gnt)
            starve_cnt_next = (starve_cnt_reg == 4'hF) ? starve_cnt_reg : starve_cnt_reg + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt_reg <= 4'd0;
        else     starve_cnt_reg <= starve_cnt_next;
    end
`endif

    always_comb begin
        m0_gnt        = m0_req && (!m1_req || !pick_m1);
        m1_gnt        = m1_req && (!m0_req || pick_m1);
        stallreq      = m0_req && !m0_gnt;
        rom_ce        = m0_gnt || m1_gnt;
        rom_addr      = '0;
        last_gnt_next = GNT_NONE;
        if (m0_gnt) begin
            rom_addr      = m0_addr;
            last_gnt_next = GNT_M0;
        end else if (m1_gnt) begin
            rom_addr      = m1_addr;
            last_gnt_next = GNT_M1;
        end
    end

    assign gnt_vec = {m1_gnt, m0_gnt};

    // Reset clears last_gnt, so a grant made during reset never produces a valid.
    always_ff @(posedge clk) begin
        if (rst) last_gnt_reg <= GNT_NONE;
        else     last_gnt_reg <= last_gnt_next;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_capture
            always_ff @(posedge clk) begin
                if (rst)              rdata_reg[gi] <= '0;
                else if (gnt_vec[gi]) rdata_reg[gi] <= rom_inst;
            end
        end
    endgenerate

    assign m0_rdata = rdata_reg[0];
    assign m1_rdata = rdata_reg[1];
    assign m0_valid = (last_gnt_reg == GNT_M0);
    assign m1_valid = (last_gnt_reg == GNT_M1);

endmodule
